// File: rtl/ins_fetch.sv
// rtl/ins_fetch.sv - fetch stage: PC, I-cache request FSM, 2-bit BHT prediction, ROB redirect
`timescale 1ns/1ps
module ins_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          BHT_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_valid,
  input  logic [31:0] ic_ins,
  input  logic        f_stall,
  output logic        is_ins,
  output logic [31:0] ins_addr,
  output logic [31:0] ins,
  output logic        pred_jmp,
  output logic [31:0] pred_another,
  input  logic        rob_clear,
  input  logic [31:0] rob_new_pc,
  input  logic        bht_upd,
  input  logic [31:0] bht_upd_pc,
  input  logic        bht_upd_taken
);

  localparam int BHT_N = 1 << BHT_BITS;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t              state, state_nxt;
  logic [31:0]         pc;
  logic [1:0]          bht [BHT_N];
  logic [31:0]         hold_ins, hold_next, hold_another;
  logic                hold_jmp;
  logic                present, capture, req_set, req_clr;

  logic [BHT_BITS-1:0] look_idx, upd_idx;
  logic [31:0]         imm_b, imm_j, pc_plus4, pc_b, pc_j;
  logic                live_jmp, taken;
  logic [31:0]         live_next, live_another;
  logic [31:0]         cur_ins, cur_next, cur_another;
  logic                cur_jmp;
  logic                unused_bits;

  assign unused_bits = &{1'b0, bht_upd_pc[31:BHT_BITS+2], bht_upd_pc[1:0]};

  assign look_idx = pc[BHT_BITS+1:2];
  assign upd_idx  = bht_upd_pc[BHT_BITS+1:2];
  assign imm_b    = {{19{ic_ins[31]}}, ic_ins[31], ic_ins[7], ic_ins[30:25], ic_ins[11:8], 1'b0};
  assign imm_j    = {{11{ic_ins[31]}}, ic_ins[31], ic_ins[19:12], ic_ins[20], ic_ins[30:21], 1'b0};
  assign pc_plus4 = pc + 32'd4;
  assign pc_b     = pc + imm_b;
  assign pc_j     = pc + imm_j;
  assign taken    = bht[look_idx][1];

  // Prediction for the word arriving this cycle; reads the BHT before any same-edge update
  always_comb begin
    live_jmp     = 1'b0;
    live_next    = pc_plus4;
    live_another = 32'h0;
    case (ic_ins[6:0])
      OP_BRANCH: begin
        live_jmp     = taken;
        live_next    = taken ? pc_b : pc_plus4;
        live_another = taken ? pc_plus4 : pc_b;
      end
      OP_JAL: begin
        live_jmp     = 1'b1;
        live_next    = pc_j;
        live_another = pc_plus4;
      end
      default: ;
    endcase
  end

  assign cur_ins     = (state == S_HOLD) ? hold_ins     : ic_ins;
  assign cur_jmp     = (state == S_HOLD) ? hold_jmp     : live_jmp;
  assign cur_next    = (state == S_HOLD) ? hold_next    : live_next;
  assign cur_another = (state == S_HOLD) ? hold_another : live_another;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= S_REQ;
    else if (rdy_in) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    present   = 1'b0;
    capture   = 1'b0;
    req_set   = 1'b0;
    req_clr   = 1'b0;
    if (rob_clear) begin
      case (state)
        S_WAIT: begin
          req_clr   = ic_valid;
          state_nxt = ic_valid ? S_REQ : S_DRAIN;
        end
        S_DRAIN: if (ic_valid) begin
          req_clr   = 1'b1;
          state_nxt = S_REQ;
        end
        default: state_nxt = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          req_set   = 1'b1;
          state_nxt = S_WAIT;
        end
        S_WAIT: if (ic_valid) begin
          req_clr = 1'b1;
          capture = 1'b1;
          if (f_stall) state_nxt = S_HOLD;
          else begin
            present   = 1'b1;
            state_nxt = S_REQ;
          end
        end
        S_HOLD: if (!f_stall) begin
          present   = 1'b1;
          state_nxt = S_REQ;
        end
        S_DRAIN: if (ic_valid) begin
          req_clr   = 1'b1;
          state_nxt = S_REQ;
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc           <= RESET_PC;
      ic_req       <= 1'b0;
      ic_addr      <= 32'h0;
      is_ins       <= 1'b0;
      ins_addr     <= 32'h0;
      ins          <= 32'h0;
      pred_jmp     <= 1'b0;
      pred_another <= 32'h0;
      hold_ins     <= 32'h0;
      hold_jmp     <= 1'b0;
      hold_next    <= 32'h0;
      hold_another <= 32'h0;
    end else if (rdy_in) begin
      is_ins <= present;
      if (present) begin
        ins_addr     <= pc;
        ins          <= cur_ins;
        pred_jmp     <= cur_jmp;
        pred_another <= cur_another;
      end
      if (capture) begin
        hold_ins     <= ic_ins;
        hold_jmp     <= live_jmp;
        hold_next    <= live_next;
        hold_another <= live_another;
      end
      if (rob_clear) pc <= rob_new_pc;
      else if (present) pc <= cur_next;
      if (req_set) begin
        ic_req  <= 1'b1;
        ic_addr <= pc;
      end else if (req_clr) begin
        ic_req <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (rdy_in && bht_upd) begin
      if (bht_upd_taken && bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'b01;
      else if (!bht_upd_taken && bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'b01;
    end
  end

endmodule

// File: tb/tb_ins_fetch.sv
// tb/tb_ins_fetch.sv - directed bench for ins_fetch with a zero-latency cache model
`timescale 1ns/1ps
module tb_ins_fetch;

  localparam logic [31:0] ADDI1 = 32'h00100093;
  localparam logic [31:0] ADDI2 = 32'h00200113;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] JAL16 = 32'h0100006F;
  localparam logic [31:0] BEQM8 = 32'hFE000CE3;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, f_stall, rob_clear, bht_upd, bht_upd_taken;
  logic [31:0] rob_new_pc, bht_upd_pc;
  logic        ic_req, ic_valid, is_ins, pred_jmp;
  logic [31:0] ic_addr, ic_ins, ins_addr, ins, pred_another;

  logic [31:0] mem [256];
  logic        auto_resp, man_valid;
  logic [31:0] man_ins;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] p_addr[$], p_ins[$], p_pa[$], r_addr[$];
  logic        p_pj[$];
  int          dup_cnt = 0;
  int          stall_viol = 0;
  logic        ins_d = 1'b0;
  logic        req_d = 1'b0;
  logic        stall_smp = 1'b0;
  logic [31:0] old_a;

  typedef struct { int n; logic t; logic pj; } train_t;
  train_t trn [5];

  assign ic_valid = auto_resp ? ic_req : man_valid;
  assign ic_ins   = auto_resp ? mem[ic_addr[9:2]] : man_ins;

  ins_fetch #(.RESET_PC(32'h0), .BHT_BITS(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_ins(ic_ins),
    .f_stall(f_stall), .is_ins(is_ins), .ins_addr(ins_addr), .ins(ins),
    .pred_jmp(pred_jmp), .pred_another(pred_another),
    .rob_clear(rob_clear), .rob_new_pc(rob_new_pc),
    .bht_upd(bht_upd), .bht_upd_pc(bht_upd_pc), .bht_upd_taken(bht_upd_taken)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_q();
    p_addr.delete(); p_ins.delete(); p_pa.delete(); p_pj.delete(); r_addr.delete();
  endtask

  task automatic redirect(input logic [31:0] a);
    rob_clear = 1'b1; rob_new_pc = a;
    tick();
    rob_clear = 1'b0;
    clear_q();
  endtask

  task automatic wait_ins(input int n);
    for (int i = 0; i < 200 && p_addr.size() < n; i++) tick();
    check("ins_timeout", 32'(p_addr.size() >= n), 32'd1);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50 && !ic_req; i++) tick();
    check("req_timeout", 32'(ic_req), 32'd1);
  endtask

  task automatic train(input logic [31:0] a, input logic t, input int n);
    for (int i = 0; i < n; i++) begin
      bht_upd = 1'b1; bht_upd_pc = a; bht_upd_taken = t;
      tick();
      bht_upd = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk_in);
    stall_smp = f_stall;
  end

  initial forever begin
    @(negedge clk_in);
    if (is_ins) begin
      p_addr.push_back(ins_addr); p_ins.push_back(ins);
      p_pj.push_back(pred_jmp);   p_pa.push_back(pred_another);
      if (ins_d) dup_cnt++;
      if (stall_smp) stall_viol++;
    end
    ins_d = is_ins;
    if (ic_req && !req_d) r_addr.push_back(ic_addr);
    req_d = ic_req;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = NOP;
    mem[0] = ADDI1; mem[1] = ADDI2; mem[8'h40] = JAL16; mem[8'h80] = BEQM8;
    trn[0] = '{4, 1'b1, 1'b1};
    trn[1] = '{1, 1'b0, 1'b1};
    trn[2] = '{4, 1'b0, 1'b0};
    trn[3] = '{1, 1'b1, 1'b0};
    trn[4] = '{1, 1'b1, 1'b1};
    rst_in = 1'b1; rdy_in = 1'b1; f_stall = 1'b0; rob_clear = 1'b0; rob_new_pc = 32'h0;
    bht_upd = 1'b0; bht_upd_pc = 32'h0; bht_upd_taken = 1'b0;
    auto_resp = 1'b1; man_valid = 1'b0; man_ins = 32'h0;
    tick(); tick();
    check("rst_ic_req", 32'(ic_req), 32'd0);
    check("rst_is_ins", 32'(is_ins), 32'd0);
    check("rst_ins_addr", ins_addr, 32'h0);
    check("rst_ins", ins, 32'h0);
    check("rst_pred_jmp", 32'(pred_jmp), 32'd0);
    check("rst_pred_another", pred_another, 32'h0);

    rst_in = 1'b0; clear_q();
    wait_ins(2);
    check("seq_req0", r_addr[0], 32'h0);
    check("seq_req1", r_addr[1], 32'h4);
    check("seq_addr0", p_addr[0], 32'h0);
    check("seq_ins0", p_ins[0], ADDI1);
    check("seq_pj0", 32'(p_pj[0]), 32'd0);
    check("seq_pa0", p_pa[0], 32'h0);
    check("seq_addr1", p_addr[1], 32'h4);
    check("seq_ins1", p_ins[1], ADDI2);

    redirect(32'h100);
    wait_ins(2);
    check("jal_addr", p_addr[0], 32'h100);
    check("jal_ins", p_ins[0], JAL16);
    check("jal_pj", 32'(p_pj[0]), 32'd1);
    check("jal_pa", p_pa[0], 32'h104);
    check("jal_next_req", r_addr[1], 32'h110);
    check("jal_next_addr", p_addr[1], 32'h110);

    redirect(32'h200);
    wait_ins(2);
    check("beq_pj", 32'(p_pj[0]), 32'd0);
    check("beq_pa", p_pa[0], 32'h1F8);
    check("beq_next_req", r_addr[1], 32'h204);

    for (int k = 0; k < 5; k++) begin
      train(32'h200, trn[k].t, trn[k].n);
      redirect(32'h200);
      wait_ins(2);
      check($sformatf("bht%0d_pj", k), 32'(p_pj[0]), 32'(trn[k].pj));
      check($sformatf("bht%0d_pa", k), p_pa[0], trn[k].pj ? 32'h204 : 32'h1F8);
      check($sformatf("bht%0d_next", k), r_addr[1], trn[k].pj ? 32'h1F8 : 32'h204);
    end

    rdy_in = 1'b0;
    tick();
    clear_q(); old_a = ic_addr;
    repeat (5) tick();
    check("rdy_no_ins", 32'(p_addr.size()), 32'd0);
    check("rdy_addr_hold", ic_addr, old_a);
    rdy_in = 1'b1;

    f_stall = 1'b1;
    redirect(32'h40);
    repeat (6) tick();
    check("stall_no_ins", 32'(p_addr.size()), 32'd0);
    check("stall_req_low", 32'(ic_req), 32'd0);
    f_stall = 1'b0;
    wait_ins(2);
    check("stall_addr0", p_addr[0], 32'h40);
    check("stall_ins0", p_ins[0], NOP);
    check("stall_addr1", p_addr[1], 32'h44);
    check("dup_is_ins", 32'(dup_cnt), 32'd0);
    check("is_ins_in_stall", 32'(stall_viol), 32'd0);

    auto_resp = 1'b0;
    wait_req();
    old_a = ic_addr;
    redirect(32'h300);
    check("drain_req_high", 32'(ic_req), 32'd1);
    check("drain_addr_old", ic_addr, old_a);
    tick();
    man_valid = 1'b1; man_ins = JAL16;
    tick();
    man_valid = 1'b0;
    check("drain_req_drop", 32'(ic_req), 32'd0);
    auto_resp = 1'b1;
    wait_ins(1);
    check("drain_req_new", r_addr[0], 32'h300);
    check("drain_addr", p_addr[0], 32'h300);
    check("drain_ins", p_ins[0], NOP);

    auto_resp = 1'b0;
    wait_req();
    man_valid = 1'b1; man_ins = JAL16;
    redirect(32'h300);
    man_valid = 1'b0;
    check("coin_req_drop", 32'(ic_req), 32'd0);
    check("coin_no_ins", 32'(is_ins), 32'd0);
    tick();
    check("coin_req", 32'(ic_req), 32'd1);
    check("coin_req_addr", ic_addr, 32'h300);
    auto_resp = 1'b1;
    wait_ins(1);
    check("coin_addr", p_addr[0], 32'h300);

    train(32'h200, 1'b1, 2);
    f_stall = 1'b1;
    redirect(32'h100);
    repeat (4) tick();
    #3;
    rst_in = 1'b1;
    #1;
    check("arst_is_ins", 32'(is_ins), 32'd0);
    check("arst_ic_req", 32'(ic_req), 32'd0);
    check("arst_ins_addr", ins_addr, 32'h0);
    check("arst_ins", ins, 32'h0);
    tick();
    rst_in = 1'b0; f_stall = 1'b0;
    clear_q();
    wait_ins(1);
    check("arst_req0", r_addr[0], 32'h0);
    check("arst_addr0", p_addr[0], 32'h0);
    redirect(32'h200);
    wait_ins(1);
    check("arst_bht_pj", 32'(p_pj[0]), 32'd0);
    check("arst_bht_pa", p_pa[0], 32'h1F8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
